// File: rtl/seg_scan_drv.sv
// seg_scan_drv: multiplexed seven-segment scan driver for up to 8 hex digits.
// A rising edge on clk_1khz steps the scan by one digit. Every step first
// holds all digits off for BLANK_CYC clocks (anti-ghosting) and then enables
// the new digit. The displayed value is latched once per frame, at the wrap
// back to digit 0. All outputs come straight from registers.
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
module seg_scan_drv #(
  parameter int DIGITS         = 8,
  parameter int BLANK_CYC      = 54,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clk_1khz,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  output logic [7:0]  seg_sel,
  output logic [7:0]  seg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [7:0] SEL_OFF   = COM_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] IDX_LAST  = 3'(DIGITS - 1);
  localparam logic [7:0] BCNT_LOAD = 8'(BLANK_CYC - 1);

  state_t      state;
  state_t      state_n;
  logic [2:0]  idx;
  logic [2:0]  idx_n;
  logic [7:0]  bcnt;
  logic [7:0]  bcnt_n;
  logic        latch;
  logic        clk_1khz_d;
  logic        armed;
  logic        tick;
  logic [31:0] data_r;
  logic [7:0]  dp_r;
  logic [4:0]  nib_base;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic [7:0]  sel_n;
  logic [7:0]  seg_n;

  // Active-high glyph for one hex nibble, segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // The strobe must be seen low once after reset before a rising edge counts,
  // so releasing reset while clk_1khz is high never fakes a tick.
  assign tick = clk_1khz & ~clk_1khz_d & armed;

  // Strobe edge detector: delayed copy of clk_1khz plus the post-reset arm flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_1khz_d <= 1'b0;
      armed      <= 1'b0;
    end else begin
      clk_1khz_d <= clk_1khz;
      armed      <= 1'b1;
    end
  end

  // Next-state logic: enable drop wins, otherwise step on ticks and count the gap
  always_comb begin
    state_n = state;
    idx_n   = idx;
    bcnt_n  = bcnt;
    latch   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = 3'd0;
      bcnt_n  = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            idx_n   = 3'd0;
            latch   = 1'b1;
            bcnt_n  = BCNT_LOAD;
            state_n = BLANK;
          end
        end
        BLANK: begin
          if (bcnt == 8'd0) begin
            state_n = SHOW;
          end else begin
            bcnt_n = bcnt - 8'd1;
          end
        end
        SHOW: begin
          if (tick) begin
            if (idx == IDX_LAST) begin
              idx_n = 3'd0;
              latch = 1'b1;
            end else begin
              idx_n = idx + 3'd1;
            end
            bcnt_n  = BCNT_LOAD;
            state_n = BLANK;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = 3'd0;
        end
      endcase
    end
  end

  // Scan state, digit index and blank-gap counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= 3'd0;
      bcnt  <= 8'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      bcnt  <= bcnt_n;
    end
  end

  // Frame latch: display value is captured only when the scan restarts at digit 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_r <= 32'd0;
      dp_r   <= 8'd0;
    end else if (latch) begin
      data_r <= data;
      dp_r   <= dp;
    end
  end

  assign nib_base = {idx, 2'b00};
  assign nib      = data_r[nib_base +: 4];

`ifdef SEG_LZB_EN
  logic [7:0] lzb_mask;
  logic       zero_run;

  // Leading-zero mask: a digit is blank while it and every digit above it is 0
  always_comb begin
    lzb_mask = 8'd0;
    zero_run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (k < DIGITS) begin
        zero_run    = zero_run & (data_r[4*k +: 4] == 4'h0);
        lzb_mask[k] = zero_run;
      end
    end
  end

  assign glyph = lzb_mask[idx] ? 7'h00 : hex7(nib);
`else
  assign glyph = hex7(nib);
`endif

  // Output image for the current state, in board polarity
  always_comb begin
    sel_n = SEL_OFF;
    seg_n = SEG_OFF;
    if (state == SHOW) begin
      sel_n = 8'h01 << idx;
      seg_n = {dp_r[idx], glyph};
      if (COM_ACTIVE_LOW) begin
        sel_n = ~sel_n;
      end
      if (SEG_ACTIVE_LOW) begin
        seg_n = ~seg_n;
      end
    end
  end

  // Output registers: the pins lag the scan state by one clock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_sel  <= SEL_OFF;
      seg_data <= SEG_OFF;
    end else begin
      seg_sel  <= sel_n;
      seg_data <= seg_n;
    end
  end

endmodule
